// File: rtl/conv_isa_pkg.sv
// Shared ISA definitions for the convolution processor: widths, opcodes and the
// fetch sequencer state encoding (STALL exists only when SEQ_STEP_EN is defined).
package conv_isa_pkg;

   localparam int ADDR_W  = 9;
   localparam int INSTR_W = 16;
   localparam int OPC_W   = 6;

   localparam logic [OPC_W-1:0] OPC_CLAC    = 6'd2;
   localparam logic [OPC_W-1:0] OPC_MVACMAR = 6'd3;
   localparam logic [OPC_W-1:0] OPC_LDAC    = 6'd4;
   localparam logic [OPC_W-1:0] OPC_STAC    = 6'd5;
   localparam logic [OPC_W-1:0] OPC_MVACR   = 6'd6;
   localparam logic [OPC_W-1:0] OPC_MVRAC   = 6'd7;
   localparam logic [OPC_W-1:0] OPC_ADD     = 6'd8;
   localparam logic [OPC_W-1:0] OPC_SUB     = 6'd9;
   localparam logic [OPC_W-1:0] OPC_INCAC   = 6'd10;
   localparam logic [OPC_W-1:0] OPC_MUL     = 6'd11;
   localparam logic [OPC_W-1:0] OPC_NOP     = 6'd46;
   localparam logic [OPC_W-1:0] OPC_JUMPNZ  = 6'd47;
   localparam logic [OPC_W-1:0] OPC_JUMPZ   = 6'd52;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_ADDR,
      SEQ_DATA,
      SEQ_ISSUE,
`ifdef SEQ_STEP_EN
      SEQ_HALT,
      SEQ_STALL
`else
      SEQ_HALT
`endif
   } seq_state_e;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: OPC_W];
   endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Instruction RAM port plus the decoder valid/ready handshake and the Z flag
// seen by the fetch sequencer.
interface instr_fetch_sequencer_if;
   import conv_isa_pkg::*;

   logic [ADDR_W-1:0]  ram_addr;
   logic [INSTR_W-1:0] ram_data;
   logic               z_flag;
   logic [INSTR_W-1:0] instr_out;
   logic               instr_valid;
   logic               instr_ready;

   modport master (
      output ram_addr,
      input  ram_data,
      input  z_flag,
      output instr_out,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      input  ram_addr,
      output ram_data,
      output z_flag,
      input  instr_out,
      input  instr_valid,
      output instr_ready
   );

endinterface

// File: rtl/instr_fetch_sequencer.sv
// Program sequencer: owns the PC, fetches from a 1-cycle synchronous RAM, resolves
// JUMPZ/JUMPNZ locally and issues everything else. `SEQ_STEP_EN adds a step-gated STALL.
module instr_fetch_sequencer
   import conv_isa_pkg::*;
#(
   parameter logic [ADDR_W-1:0] START_PC = '0,
   parameter logic [OPC_W-1:0]  HALT_OPC = OPC_NOP
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
`ifdef SEQ_STEP_EN
   input  logic                      step,
`endif
   instr_fetch_sequencer_if.master   bus,
   output logic [ADDR_W-1:0]         pc_out,
   output logic                      busy,
   output logic                      halted,
   output logic                      jump_taken
);

   localparam logic [ADDR_W-1:0] PC_ONE = 1;

   seq_state_e         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;
   logic               jump_q, jump_d;

   logic [OPC_W-1:0]   opcode;
   logic [ADDR_W-1:0]  target;

   assign opcode = opcode_of(bus.ram_data);
   assign target = bus.ram_data[ADDR_W-1:0];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      jump_d  = 1'b0;

      unique case (state_q)
         SEQ_IDLE: begin
            if (start) begin
               pc_d    = START_PC;
               state_d = SEQ_ADDR;
            end
         end
         SEQ_ADDR: begin
            state_d = SEQ_DATA;
         end
         SEQ_DATA: begin
            // Jumps are resolved here and never reach the decoder.
            if (opcode == OPC_JUMPZ) begin
               if (bus.z_flag) begin
                  pc_d   = target;
                  jump_d = 1'b1;
               end else begin
                  pc_d = pc_q + PC_ONE;
               end
               state_d = SEQ_ADDR;
            end else if (opcode == OPC_JUMPNZ) begin
               if (!bus.z_flag) begin
                  pc_d   = target;
                  jump_d = 1'b1;
               end else begin
                  pc_d = pc_q + PC_ONE;
               end
               state_d = SEQ_ADDR;
            end else if (opcode == HALT_OPC) begin
               state_d = SEQ_HALT;
            end else begin
               instr_d = bus.ram_data;
               valid_d = 1'b1;
               state_d = SEQ_ISSUE;
            end
         end
         SEQ_ISSUE: begin
            if (valid_q && bus.instr_ready) begin
               valid_d = 1'b0;
               pc_d    = pc_q + PC_ONE;
`ifdef SEQ_STEP_EN
               state_d = SEQ_STALL;
`else
               state_d = SEQ_ADDR;
`endif
            end
         end
         SEQ_HALT: begin
            if (start) begin
               pc_d    = START_PC;
               state_d = SEQ_ADDR;
            end
         end
`ifdef SEQ_STEP_EN
         SEQ_STALL: begin
            if (step) begin
               state_d = SEQ_ADDR;
            end
         end
`endif
         default: begin
            state_d = SEQ_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEQ_IDLE;
         pc_q    <= START_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
         jump_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         jump_q  <= jump_d;
      end
   end

   assign bus.ram_addr    = pc_q;
   assign bus.instr_out   = instr_q;
   assign bus.instr_valid = valid_q;
   assign pc_out          = pc_q;
   assign jump_taken      = jump_q;
   assign halted          = (state_q == SEQ_HALT);
   assign busy            = (state_q != SEQ_IDLE) && (state_q != SEQ_HALT);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: a RAM model, a scoreboard of
// expected {pc, instruction} issues, and one task per scenario.
module tb_instr_fetch_sequencer;
   import conv_isa_pkg::*;

   localparam logic [15:0] NOP_WORD = {OPC_NOP, 10'd0};
`ifdef SEQ_STEP_EN
   localparam int ISSUE_SPACING = 4;
`else
   localparam int ISSUE_SPACING = 3;
`endif

   typedef struct {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
`ifdef SEQ_STEP_EN
   logic              step = 1'b1;
`endif
   logic [ADDR_W-1:0] pc_out;
   logic              busy;
   logic              halted;
   logic              jump_taken;

   logic [INSTR_W-1:0] mem [512];

   exp_t exp_q [$];
   int   acc_q [$];
   int   checks_total  = 0;
   int   checks_passed = 0;
   int   cycle         = 0;
   int   jump_count    = 0;

   instr_fetch_sequencer_if bus ();

   instr_fetch_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
`ifdef SEQ_STEP_EN
      .step       (step),
`endif
      .bus        (bus),
      .pc_out     (pc_out),
      .busy       (busy),
      .halted     (halted),
      .jump_taken (jump_taken)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycle++;
      bus.ram_data <= mem[bus.ram_addr];
   end

   // Scoreboard: a handshake sampled here completes at the following rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (jump_taken) jump_count++;
         if (bus.instr_valid && bus.instr_ready) begin
            acc_q.push_back(cycle);
            checks_total++;
            if (exp_q.size() == 0) begin
               $display("[TB] FAIL issue_unexpected: got pc=%0d instr=%h, required no issue", pc_out, bus.instr_out);
            end else begin
               e = exp_q.pop_front();
               if ({pc_out, bus.instr_out} !== {e.pc, e.instr})
                  $display("[TB] FAIL issue_match: got pc=%0d instr=%h, required pc=%0d instr=%h",
                           pc_out, bus.instr_out, e.pc, e.instr);
               else
                  checks_passed++;
            end
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 512; i++) mem[i] = NOP_WORD;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halt(input int budget);
      int n;
      n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks_total++;
      if (!halted) $display("[TB] FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, budget);
      else checks_passed++;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      bus.z_flag = 1'b0; bus.instr_ready = 1'b1;
      clear_mem();
      #12;
      checks_total++;
      if ({bus.ram_addr, bus.instr_out, bus.instr_valid, pc_out, busy, halted, jump_taken} !== '0)
         $display("[TB] FAIL reset_outputs: addr=%0d instr=%h valid=%b pc=%0d busy=%b halted=%b jump=%b, required all 0",
                  bus.ram_addr, bus.instr_out, bus.instr_valid, pc_out, busy, halted, jump_taken);
      else checks_passed++;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks_total++;
      if ({bus.ram_addr, busy} !== '0)
         $display("[TB] FAIL idle_hold: addr=%0d busy=%b, required 0/0", bus.ram_addr, busy);
      else checks_passed++;
   endtask

   task automatic test_straight_line();
      clear_mem();
      mem[0] = 16'h0800; mem[1] = 16'h0C00; mem[2] = 16'h1000;
      exp_q.push_back('{9'd0, 16'h0800});
      exp_q.push_back('{9'd1, 16'h0C00});
      exp_q.push_back('{9'd2, 16'h1000});
      acc_q.delete(); jump_count = 0;
      pulse_start();
      wait_halt(100);
      checks_total++;
      if (exp_q.size() != 0) $display("[TB] FAIL straight_drain: %0d pending, required 0", exp_q.size());
      else checks_passed++;
      checks_total++;
      if (acc_q.size() != 3 || acc_q[1] - acc_q[0] != ISSUE_SPACING || acc_q[2] - acc_q[1] != ISSUE_SPACING)
         $display("[TB] FAIL straight_spacing: %0d issues, required 3 spaced %0d", acc_q.size(), ISSUE_SPACING);
      else checks_passed++;
      checks_total++;
      if ({pc_out, busy, halted, bus.instr_valid, jump_count[3:0]} !== {9'd3, 1'b0, 1'b1, 1'b0, 4'd0})
         $display("[TB] FAIL straight_halt: pc=%0d busy=%b halted=%b valid=%b jumps=%0d, required 3/0/1/0/0",
                  pc_out, busy, halted, bus.instr_valid, jump_count);
      else checks_passed++;
   endtask

   task automatic test_jumpz_taken();
      clear_mem();
      bus.z_flag = 1'b1;
      mem[0]   = {OPC_JUMPZ, 10'd151};
      mem[151] = {OPC_JUMPZ, 1'b1, 9'd179};
      mem[179] = 16'h1400;
      exp_q.push_back('{9'd179, 16'h1400});
      jump_count = 0;
      pulse_start();
      wait_halt(100);
      checks_total++;
      if (exp_q.size() != 0 || jump_count != 2 || pc_out !== 9'd180)
         $display("[TB] FAIL jumpz_taken: pending=%0d jumps=%0d pc=%0d, required 0/2/180", exp_q.size(), jump_count, pc_out);
      else checks_passed++;
   endtask

   task automatic test_jumpz_untaken();
      clear_mem();
      bus.z_flag = 1'b0;
      mem[0]   = {OPC_JUMPZ, 10'd151};
      mem[1]   = 16'h0800;
      mem[151] = 16'h0C00;
      exp_q.push_back('{9'd1, 16'h0800});
      jump_count = 0;
      pulse_start();
      wait_halt(100);
      checks_total++;
      if (exp_q.size() != 0 || jump_count != 0 || pc_out !== 9'd2)
         $display("[TB] FAIL jumpz_untaken: pending=%0d jumps=%0d pc=%0d, required 0/0/2", exp_q.size(), jump_count, pc_out);
      else checks_passed++;
   endtask

   task automatic test_jumpnz();
      clear_mem();
      bus.z_flag = 1'b0;
      mem[0]   = {OPC_JUMPNZ, 10'd184};
      mem[184] = {OPC_JUMPNZ, 10'd63};
      mem[63]  = 16'h1800;
      exp_q.push_back('{9'd63, 16'h1800});
      jump_count = 0;
      pulse_start();
      wait_halt(100);
      checks_total++;
      if (exp_q.size() != 0 || jump_count != 2 || pc_out !== 9'd64)
         $display("[TB] FAIL jumpnz_taken: pending=%0d jumps=%0d pc=%0d, required 0/2/64", exp_q.size(), jump_count, pc_out);
      else checks_passed++;
   endtask

   task automatic test_halt_restart();
      clear_mem();
      bus.z_flag = 1'b1;
      mem[0]   = {OPC_JUMPZ, 10'd184};
      mem[184] = {OPC_JUMPNZ, 10'd63};
      mem[63]  = 16'h1800;
      jump_count = 0; acc_q.delete();
      pulse_start();
      wait_halt(100);
      repeat (3) @(negedge clk);
      checks_total++;
      if ({pc_out, halted, busy, bus.instr_valid} !== {9'd185, 1'b1, 1'b0, 1'b0} || jump_count != 1 || acc_q.size() != 0)
         $display("[TB] FAIL halt_state: pc=%0d halted=%b busy=%b valid=%b jumps=%0d issues=%0d, required 185/1/0/0/1/0",
                  pc_out, halted, busy, bus.instr_valid, jump_count, acc_q.size());
      else checks_passed++;
      clear_mem();
      mem[0] = 16'h0800;
      exp_q.push_back('{9'd0, 16'h0800});
      pulse_start();
      checks_total++;
      if ({halted, busy, bus.ram_addr} !== {1'b0, 1'b1, 9'd0})
         $display("[TB] FAIL restart: halted=%b busy=%b addr=%0d, required 0/1/0", halted, busy, bus.ram_addr);
      else checks_passed++;
      wait_halt(100);
      checks_total++;
      if (exp_q.size() != 0 || pc_out !== 9'd1)
         $display("[TB] FAIL restart_run: pending=%0d pc=%0d, required 0/1", exp_q.size(), pc_out);
      else checks_passed++;
   endtask

   task automatic test_pc_wrap();
      int n;
      clear_mem();
      bus.z_flag = 1'b0;
      mem[0]   = {OPC_JUMPNZ, 10'd511};
      mem[511] = 16'h0800;
      exp_q.push_back('{9'd511, 16'h0800});
      jump_count = 0;
      pulse_start();
      n = 0;
      while (!bus.instr_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.z_flag = 1'b1;
      wait_halt(100);
      checks_total++;
      if (exp_q.size() != 0 || jump_count != 1 || pc_out !== 9'd1)
         $display("[TB] FAIL pc_wrap: pending=%0d jumps=%0d pc=%0d, required 0/1/1", exp_q.size(), jump_count, pc_out);
      else checks_passed++;
   endtask

   task automatic test_backpressure();
      int n;
      clear_mem();
      mem[0] = 16'h0C00;
      bus.instr_ready = 1'b0;
      exp_q.push_back('{9'd0, 16'h0C00});
      acc_q.delete();
      pulse_start();
      n = 0;
      while (!bus.instr_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks_total++;
         if ({bus.instr_valid, bus.instr_out, pc_out} !== {1'b1, 16'h0C00, 9'd0})
            $display("[TB] FAIL backpressure_hold: valid=%b instr=%h pc=%0d, required 1/0c00/0", bus.instr_valid, bus.instr_out, pc_out);
         else checks_passed++;
      end
      @(posedge clk);
      #1 bus.instr_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks_total++;
      if ({bus.instr_valid, pc_out} !== {1'b0, 9'd1} || acc_q.size() != 1)
         $display("[TB] FAIL backpressure_accept: valid=%b pc=%0d issues=%0d, required 0/1/1", bus.instr_valid, pc_out, acc_q.size());
      else checks_passed++;
      wait_halt(100);
   endtask

   task automatic test_reset_mid_issue();
      int n;
      clear_mem();
      mem[0] = 16'h1000;
      bus.instr_ready = 1'b0;
      pulse_start();
      n = 0;
      while (!bus.instr_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      #2 rst = 1'b1;
      #1;
      checks_total++;
      if ({bus.instr_valid, bus.instr_out, pc_out, busy, halted} !== '0)
         $display("[TB] FAIL reset_mid_issue: valid=%b instr=%h pc=%0d busy=%b halted=%b, required all 0",
                  bus.instr_valid, bus.instr_out, pc_out, busy, halted);
      else checks_passed++;
      @(negedge clk);
      rst = 1'b0;
      bus.instr_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks_total++;
      if ({bus.ram_addr, busy, halted, bus.instr_valid} !== '0 || exp_q.size() != 0)
         $display("[TB] FAIL reset_idle: addr=%0d busy=%b halted=%b valid=%b pending=%0d, required all 0",
                  bus.ram_addr, busy, halted, bus.instr_valid, exp_q.size());
      else checks_passed++;
   endtask

   initial begin
      test_reset();
      test_straight_line();
      test_jumpz_taken();
      test_jumpz_untaken();
      test_jumpnz();
      test_halt_restart();
      test_pc_wrap();
      test_backpressure();
      test_reset_mid_issue();
      $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
Program sequencer for the convolution processor. It owns the program counter and drives the synchronous instruction RAM (9-bit address, 16-bit word, 1-cycle read latency). It resolves JUMPZ/JUMPNZ locally using the datapath Z flag, stops on the halt opcode, and hands every other instruction to the control-unit decoder over a valid/ready handshake.

Parameters:
ADDR_W, 9, instruction RAM address width / PC width
INSTR_W, 16, instruction word width
OPC_W, 6, opcode field width (instr[15:10])
START_PC, 0, PC loaded on start
HALT_OPC, 46, opcode that halts the sequencer (NOP)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  1-cycle pulse; leaves IDLE/HALT and begins fetch at START_PC
ram_addr  out  ADDR_W  address to instruction RAM
ram_data  in  INSTR_W  RAM read data, valid one cycle after address is captured
z_flag  in  1  datapath zero flag, stable whenever instr_ready=1
instr_out  out  INSTR_W  registered instruction to decoder
instr_valid  out  1  instr_out holds an instruction to execute
instr_ready  in  1  decoder accepts instr_out; previous instruction complete
pc_out  out  ADDR_W  current PC
busy  out  1  high in any state except IDLE and HALT
halted  out  1  high in HALT
jump_taken  out  1  1-cycle pulse when a jump is taken

Behaviour:
- Reset (async, any state): state=IDLE, pc=START_PC, ram_addr=0, instr_out=0, instr_valid=0, busy=0, halted=0, jump_taken=0.
- ram_addr = pc, combinational from the PC register.
- States: IDLE, ADDR, DATA, ISSUE, HALT.
- IDLE: wait for start. start -> pc=START_PC, go to ADDR.
- ADDR: the RAM captures pc at this edge. Go to DATA.
- DATA: ram_data is valid. Decode opcode = ram_data[15:10]:
  - JUMPZ (52): if z_flag=1, pc=ram_data[8:0] and jump_taken pulses; else pc=pc+1. Go to ADDR.
  - JUMPNZ (47): if z_flag=0, pc=ram_data[8:0] and jump_taken pulses; else pc=pc+1. Go to ADDR.
  - HALT_OPC: go to HALT; pc is unchanged.
  - Any other opcode: instr_out=ram_data, instr_valid=1, go to ISSUE.
- ISSUE: hold instr_out and instr_valid stable. On instr_valid&&instr_ready: instr_valid=0, pc=pc+1, go to ADDR. When instr_ready=0, wait indefinitely with no change.
- HALT: halted=1. start -> pc=START_PC, halted=0, go to ADDR.
- Jumps and halt are never forwarded to the decoder.
- Jump target is operand bits [8:0]; operand bit 9 is ignored.
- Latency: a non-jump instruction reaches instr_valid 2 cycles after entering ADDR. With instr_ready tied high, throughput is 1 instruction per 3 cycles. A taken or untaken jump costs 2 cycles.
- PC arithmetic is modulo 2^ADDR_W: pc=511 followed by +1 gives 0.
- start is ignored in ADDR, DATA and ISSUE.
- z_flag is sampled only in DATA. The sequencer relies on the fact that the previous instruction retired before the decoder asserted ready.
- Reset asserted mid-ISSUE drops instr_valid asynchronously. No partial handshake is completed.

Optional Feature:
SEQ_STEP_EN: adds input step (1-bit pulse).
- Defined: after each ISSUE handshake, the FSM enters a STALL state with pc already incremented. A step pulse moves it to ADDR. Jumps do not stall. busy stays 1 in STALL.
- Undefined: no step port, no STALL state, behaviour exactly as above.

Decomposition:
- Shared package conv_isa_pkg: OPC_W, INSTR_W, ADDR_W, and the opcode constants (JUMPZ=52, JUMPNZ=47, NOP=46, plus the full ISA opcode list used by the decoder). It also holds a state enum typedef for the sequencer.
- No sub-module: the next-PC mux and FSM stay in one module.

Test Plan:
- Reset/idle: assert rst mid-run -> all outputs 0, state IDLE; no ram_addr change until start.
- Straight line: RAM[0..2] = CLAC, MVACMAR, LDAC, instr_ready=1, start -> instr_out = 0x0800, 0x0C00, 0x1000 in order; instr_valid spaced 3 cycles apart; ram_addr 0, 1, 2.
- JUMPZ taken: RAM[151]={52,10'd179}, z_flag=1 -> jump_taken pulse, next ram_addr=179, JUMPZ never on instr_out. With z_flag=0 -> next ram_addr=152.
- JUMPNZ: RAM[184]={47,10'd63}, z_flag=0 -> ram_addr=63. With z_flag=1 -> ram_addr=185.
- Backpressure: instr_ready=0 for 5 cycles in ISSUE -> instr_out and pc_out constant, instr_valid held 1; then ready=1 -> single acceptance, pc+1.
- Halt/restart: RAM[185]=NOP -> halted=1, busy=0, instr_valid stays 0. start -> fetch resumes at address 0.
